alu_muldiv_seq: RTL and testbench

Multi-cycle sequencer that reuses the shared 16-bit ALU (ALU_16) to execute 16x16 multiply and 16/16 divide, one iteration per clock.
Sits between the CPU execute stage and ALU_16. While idle, it passes the CPU's ALU operation through unchanged. While a mul/div runs, it takes ownership of the ALU and asserts busy so the pipeline stalls.

---
 rtl/alu_muldiv_seq_pkg.sv | 29 ++
 rtl/alu_cb_gen.sv | 28 ++
 rtl/alu_muldiv_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq_pkg
//   Shared constants for the mul/div sequencer that borrows ALU_16:
//   operand/counter widths, the two ALU_16 op codes the sequencer drives,
//   the sequencer op codes and the FSM state encodings.
// ---------------------------------------------------------------------------
package alu_muldiv_seq_pkg;

  localparam int SEQ_WIDTH = 16;  // ALU_16 datapath width
  localparam int SEQ_CNT_W = 5;   // iteration counter, must hold SEQ_WIDTH

  // ALU_16 operation codes used by the sequencer
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  // Sequencer operations (op[1] selects signed when SEQ_SIGNED_EN is built)
  localparam logic [1:0] SEQ_OP_MUL  = 2'b00;
  localparam logic [1:0] SEQ_OP_DIVU = 2'b01;
  localparam logic [1:0] SEQ_OP_MULS = 2'b10;
  localparam logic [1:0] SEQ_OP_DIVS = 2'b11;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_NEG_IN  = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_NEG_OUT = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/alu_cb_gen.sv
// ---------------------------------------------------------------------------
// alu_cb_gen
//   Recovers the carry-out of an ALU_16 add and the borrow-out of an ALU_16
//   subtract from operand and result MSBs only, since ALU_16 exposes no
//   carry flag.
// Ports:
//   i_a_msb, i_b_msb  MSBs of the ALU a/b operands
//   i_out_msb         MSB of the ALU result
//   i_e               17th bit of the shifted remainder; when set the
//                     subtraction can never borrow
//   o_carry           carry out of a + b
//   o_borrow          borrow out of {e, a} - b
// ---------------------------------------------------------------------------
module alu_cb_gen (
  input  logic i_a_msb,
  input  logic i_b_msb,
  input  logic i_out_msb,
  input  logic i_e,
  output logic o_carry,
  output logic o_borrow
);

  assign o_carry  = (i_a_msb & i_b_msb) | ((i_a_msb | i_b_msb) & ~i_out_msb);

  assign o_borrow = ~i_e & ((~i_a_msb & i_b_msb) |
                            ((~i_a_msb | i_b_msb) & i_out_msb));

endmodule

// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
//   Multi-cycle 16x16 multiply / 16/16 restoring divide that time-shares the
//   external ALU_16, one iteration per clock. While idle the CPU's ALU
//   request passes straight through; while busy the sequencer owns the ALU.
// Build option:
//   SEQ_SIGNED_EN  when defined, op 10/11 are signed (NEG_IN / NEG_OUT
//                  states convert operands and results); otherwise op[1]
//                  is ignored.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, op, opa, opb           request; op/operands captured on accept
//   busy, done                    busy while owning the ALU; 1-cycle done
//   res_hi, res_lo, dz            MUL: product hi/lo; DIV: rem/quot, dz
//   cpu_alu_op/a/b                CPU ALU request, forwarded while idle
//   alu_op/a/b, alu_out           ALU_16 request / combinational result
//   alu_z, alu_v, alu_n           ALU_16 flags, deliberately not consumed
// ---------------------------------------------------------------------------
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int CNT_W = SEQ_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             dz,
  input  logic [2:0]       cpu_alu_op,
  input  logic [WIDTH-1:0] cpu_alu_a,
  input  logic [WIDTH-1:0] cpu_alu_b,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             alu_n
);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic [WIDTH-1:0] r_acc_hi;   // MUL: product high / DIV: remainder
  logic [WIDTH-1:0] r_acc_lo;   // MUL: multiplier->product low / DIV: dividend->quotient
  logic [WIDTH-1:0] r_b;        // MUL: multiplicand / DIV: divisor
  logic             r_busy, r_done, r_dz;
  logic [WIDTH-1:0] r_res_hi, r_res_lo;

  logic [2:0]       w_alu_op;
  logic [WIDTH-1:0] w_alu_a, w_alu_b;
  logic [WIDTH-1:0] w_shift, w_hi_nxt, w_lo_nxt;
  logic             w_e, w_carry, w_borrow;
  logic             w_out_fix, w_finish, w_unused_in;

`ifdef SEQ_SIGNED_EN
  logic r_fix_a, r_fix_b;       // operand still needs converting to magnitude
  logic r_fix_hi, r_fix_lo;     // result word still needs negating
  logic w_neg_a, w_neg_b;

  assign w_neg_a   = op[1] & opa[WIDTH-1];
  assign w_neg_b   = op[1] & opb[WIDTH-1];
  assign w_out_fix = r_fix_hi | r_fix_lo;
`else
  assign w_out_fix = 1'b0;
`endif

  // The sequencer never looks at ALU flags; op[1] is meaningless in the
  // unsigned-only build.
  assign w_unused_in = alu_z ^ alu_v ^ alu_n ^ op[1];

  // Divide step: remainder shifted left with the next dividend bit.
  assign w_shift = {r_acc_hi[WIDTH-2:0], r_acc_lo[WIDTH-1]};

  alu_cb_gen u_cb_gen (
    .i_a_msb   (w_alu_a[WIDTH-1]),
    .i_b_msb   (w_alu_b[WIDTH-1]),
    .i_out_msb (alu_out[WIDTH-1]),
    .i_e       (w_e),
    .o_carry   (w_carry),
    .o_borrow  (w_borrow)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    w_alu_op = ALU_ADD;
    w_alu_a  = '0;
    w_alu_b  = '0;
    w_e      = 1'b0;
    w_hi_nxt = r_acc_hi;
    w_lo_nxt = r_acc_lo;
    case (r_state)
      ST_IDLE: begin
        w_alu_op = cpu_alu_op;
        w_alu_a  = cpu_alu_a;
        w_alu_b  = cpu_alu_b;
      end
      ST_RUN: begin
        if (r_is_div) begin
          w_e      = r_acc_hi[WIDTH-1];
          w_alu_op = ALU_SUB;
          w_alu_a  = w_shift;
          w_alu_b  = r_b;
          w_hi_nxt = w_borrow ? w_shift : alu_out;
          w_lo_nxt = {r_acc_lo[WIDTH-2:0], ~w_borrow};
        end else begin
          // Shift {carry, acc_hi, acc_lo} right, adding the multiplicand
          // into the high half first when the multiplier LSB is set.
          w_alu_a  = r_acc_hi;
          w_alu_b  = r_b;
          w_hi_nxt = r_acc_lo[0] ? {w_carry, alu_out[WIDTH-1:1]}
                                 : {1'b0, r_acc_hi[WIDTH-1:1]};
          w_lo_nxt = {(r_acc_lo[0] ? alu_out[0] : r_acc_hi[0]),
                      r_acc_lo[WIDTH-1:1]};
        end
      end
`ifdef SEQ_SIGNED_EN
      ST_NEG_IN: begin
        w_alu_op = ALU_SUB;
        w_alu_b  = r_fix_a ? r_acc_lo : r_b;
      end
      ST_NEG_OUT: begin
        w_alu_op = ALU_SUB;
        if (r_fix_hi) begin
          // 32-bit product negation: high word is ~hi unless the low word
          // is zero, in which case the +1 carries into it (0 - hi).
          w_alu_a  = (!r_is_div && r_acc_lo != '0) ? '1 : '0;
          w_alu_b  = r_acc_hi;
          w_hi_nxt = alu_out;
        end else begin
          w_alu_b  = r_acc_lo;
          w_lo_nxt = alu_out;
        end
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_finish = (r_state == ST_RUN) && (r_cnt == CNT_W'(1)) && !w_out_fix;
`ifdef SEQ_SIGNED_EN
    if (r_state == ST_NEG_OUT && !(r_fix_hi && r_fix_lo)) w_finish = 1'b1;
`endif
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_b      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_res_hi <= '0;
      r_res_lo <= '0;
`ifdef SEQ_SIGNED_EN
      r_fix_a  <= 1'b0;
      r_fix_b  <= 1'b0;
      r_fix_hi <= 1'b0;
      r_fix_lo <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_is_div <= op[0];
            r_acc_hi <= '0;
            r_acc_lo <= opa;
            r_b      <= opb;   // product is symmetric, so opb drives the adder
            r_cnt    <= CNT_W'(WIDTH);
            r_busy   <= 1'b1;
            if (op[0] && opb == '0) begin
              r_res_hi <= opa;
              r_res_lo <= '1;
              r_dz     <= 1'b1;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
`ifdef SEQ_SIGNED_EN
              r_fix_a  <= w_neg_a;
              r_fix_b  <= w_neg_b;
              r_fix_hi <= op[0] ? w_neg_a : (w_neg_a ^ w_neg_b);
              r_fix_lo <= w_neg_a ^ w_neg_b;
              r_state  <= (w_neg_a | w_neg_b) ? ST_NEG_IN : ST_RUN;
`else
              r_state  <= ST_RUN;
`endif
            end
          end
        end
        ST_RUN: begin
          r_acc_hi <= w_hi_nxt;
          r_acc_lo <= w_lo_nxt;
          r_cnt    <= r_cnt - 1'b1;
`ifdef SEQ_SIGNED_EN
          if (r_cnt == CNT_W'(1) && w_out_fix) r_state <= ST_NEG_OUT;
`endif
        end
`ifdef SEQ_SIGNED_EN
        ST_NEG_IN: begin
          if (r_fix_a) begin
            r_acc_lo <= alu_out;
            r_fix_a  <= 1'b0;
          end else begin
            r_b      <= alu_out;
            r_fix_b  <= 1'b0;
          end
          if (!(r_fix_a && r_fix_b)) r_state <= ST_RUN;
        end
        ST_NEG_OUT: begin
          r_acc_hi <= w_hi_nxt;
          r_acc_lo <= w_lo_nxt;
          if (r_fix_hi) r_fix_hi <= 1'b0;
          else          r_fix_lo <= 1'b0;
        end
`endif
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      // Last datapath step: publish results and enter the done cycle.
      if (w_finish) begin
        r_res_hi <= w_hi_nxt;
        r_res_lo <= w_lo_nxt;
        r_dz     <= 1'b0;
        r_done   <= 1'b1;
        r_state  <= ST_DONE;
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign dz     = r_dz;
  assign res_hi = r_res_hi;
  assign res_lo = r_res_lo;
  assign alu_op = w_alu_op;
  assign alu_a  = w_alu_a;
  assign alu_b  = w_alu_b;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv_seq
//   Self-checking bench for alu_muldiv_seq. Models ALU_16 (add/sub), keeps an
//   arithmetic reference model of results and latency, compares DUT outputs
//   against it every cycle, and drives directed vectors with literal
//   expectations.
// ---------------------------------------------------------------------------
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] opa = '0, opb = '0;
  logic        busy, done, dz;
  logic [15:0] res_hi, res_lo;
  logic [2:0]  cpu_alu_op = ALU_ADD;
  logic [15:0] cpu_alu_a = '0, cpu_alu_b = '0;
  logic [2:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_out;
  logic        alu_z, alu_v, alu_n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // ALU_16 stand-in
  assign alu_out = (alu_op == ALU_ADD) ? alu_a + alu_b :
                   (alu_op == ALU_SUB) ? alu_a - alu_b : (alu_a & alu_b);
  assign alu_z = (alu_out == 16'h0);
  assign alu_n = alu_out[15];
  assign alu_v = 1'b0;

  alu_muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo), .dz(dz),
    .cpu_alu_op(cpu_alu_op), .cpu_alu_a(cpu_alu_a), .cpu_alu_b(cpu_alu_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .alu_z(alu_z), .alu_v(alu_v), .alu_n(alu_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: results from plain arithmetic, latency from the cycle rules
  // (edges from accept until done is seen).
  function automatic void model_op(input logic [1:0] o, input logic [15:0] a, b,
                                   output logic [15:0] hi, lo, output logic z,
                                   output int lat);
    logic [31:0] p;
    logic [15:0] ma, mb, q, r;
    logic        sgn, na, nb;
    sgn = 1'b0;
`ifdef SEQ_SIGNED_EN
    sgn = o[1];
`endif
    na  = sgn & a[15];
    nb  = sgn & b[15];
    ma  = na ? 16'(-a) : a;
    mb  = nb ? 16'(-b) : b;
    lat = 17 + int'(na) + int'(nb);
    z   = 1'b0;
    if (!o[0]) begin
      p = {16'h0, ma} * {16'h0, mb};
      if (na ^ nb) begin p = -p; lat += 2; end
      hi = p[31:16];
      lo = p[15:0];
    end else if (b == 16'h0) begin
      z = 1'b1; hi = a; lo = 16'hFFFF; lat = 1;
    end else begin
      q = ma / mb;
      r = ma % mb;
      if (na ^ nb) begin q = -q; lat++; end
      if (na)      begin r = -r; lat++; end
      hi = r;
      lo = q;
    end
  endfunction

  // Model state: m_cnt = cycles left until idle (1 = done cycle).
  int          m_cnt = 0;
  bit          m_on = 0;
  logic [15:0] m_hi = '0, m_lo = '0, p_hi, p_lo;
  logic        m_dz = 1'b0, p_dz;
  int          p_lat;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_on = 1; m_cnt = 0; m_hi = '0; m_lo = '0; m_dz = 1'b0;
    end else if (m_on) begin
      if (m_cnt > 0) m_cnt--;
      else if (start) begin
        model_op(op, opa, opb, p_hi, p_lo, p_dz, p_lat);
        m_cnt = p_lat;
      end
      if (m_cnt == 1) begin m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; end
    end
  end

  // Per-cycle compare against the model, sampled mid-low-phase.
  initial forever begin
    @(negedge clk);
    #1;
    if (m_on) begin
      check("cyc_busy", busy, m_cnt > 0);
      check("cyc_done", done, m_cnt == 1);
      if (m_cnt <= 1) begin
        check("cyc_res_hi", res_hi, m_hi);
        check("cyc_res_lo", res_lo, m_lo);
        check("cyc_dz", dz, m_dz);
      end
      if (m_cnt == 0) begin
        check("cyc_pt_op", alu_op, cpu_alu_op);
        check("cyc_pt_a", alu_a, cpu_alu_a);
        check("cyc_pt_b", alu_b, cpu_alu_b);
      end
    end
  end

  // Called at the first negedge after the accepting edge; n counts negedges.
  task automatic wait_done(output int n, output bit seen);
    n = 1;
    seen = 0;
    while (n <= 60 && !seen) begin
      if (done === 1'b1) seen = 1;
      else begin @(negedge clk); n++; end
    end
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [15:0] a, b,
                        input logic [15:0] ehi, elo, input logic edz, input int elat);
    int n;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(n, seen);
    check({nm, "_done_seen"}, seen, 1'b1);
    check({nm, "_latency"}, n, elat);
    check({nm, "_res_hi"}, res_hi, ehi);
    check({nm, "_res_lo"}, res_lo, elo);
    check({nm, "_dz"}, dz, edz);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, nd;
    bit  seen;
    logic [2:0]  s_op;
    logic [15:0] s_a, s_b;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_res_hi", res_hi, 16'h0);
    check("rst_res_lo", res_lo, 16'h0);
    check("rst_dz", dz, 1'b0);

    // Idle pass-through
    cpu_alu_op = ALU_SUB; cpu_alu_a = 16'd2; cpu_alu_b = 16'd1;
    #2;
    check("pt_op", alu_op, ALU_SUB);
    check("pt_a", alu_a, 16'd2);
    check("pt_b", alu_b, 16'd1);
    check("pt_out", alu_out, 16'd1);

    run_op("mul_1234x10", SEQ_OP_MUL, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0, 17);
    run_op("mul_ffffxffff", SEQ_OP_MUL, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17);
    run_op("mul_8000x2", SEQ_OP_MUL, 16'h8000, 16'h0002, 16'h0001, 16'h0000, 1'b0, 17);
    run_op("divu_100_7", SEQ_OP_DIVU, 16'd100, 16'd7, 16'd2, 16'd14, 1'b0, 17);
    run_op("divu_ffff_1", SEQ_OP_DIVU, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 17);
    run_op("divu_8000_3", SEQ_OP_DIVU, 16'h8000, 16'h0003, 16'h0002, 16'h2AAA, 1'b0, 17);
    run_op("divu_5_9", SEQ_OP_DIVU, 16'd5, 16'd9, 16'd5, 16'd0, 1'b0, 17);
    run_op("divu_by0", SEQ_OP_DIVU, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1);
`ifdef SEQ_SIGNED_EN
    run_op("divs_m7_2", SEQ_OP_DIVS, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, 20);
    run_op("muls_m3_5", SEQ_OP_MULS, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 1'b0, 20);
`else
    run_op("op10_as_mul", SEQ_OP_MULS, 16'hFFFD, 16'h0005, 16'h0004, 16'hFFF1, 1'b0, 17);
    run_op("op11_as_divu", SEQ_OP_DIVS, 16'hFFF9, 16'h0002, 16'h0001, 16'h7FFC, 1'b0, 17);
`endif

    // Stray start in RUN, CPU-side changes in RUN, start during DONE
    @(negedge clk);
    start = 1'b1; op = SEQ_OP_MUL; opa = 16'h00FF; opb = 16'h0101;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    s_op = alu_op; s_a = alu_a; s_b = alu_b;
    start = 1'b1; op = SEQ_OP_DIVU; opa = 16'h0009; opb = 16'h0000;
    cpu_alu_op = 3'd5; cpu_alu_a = 16'hAAAA; cpu_alu_b = 16'h5555;
    #2;
    check("run_iso_op", alu_op, s_op);
    check("run_iso_a", alu_a, s_a);
    check("run_iso_b", alu_b, s_b);
    @(negedge clk);
    start = 1'b0;
    wait_done(n, seen);
    check("stray_done_seen", seen, 1'b1);
    check("stray_res_hi", res_hi, 16'h0000);
    check("stray_res_lo", res_lo, 16'hFFFF);
    start = 1'b1; op = SEQ_OP_DIVU; opa = 16'h1234; opb = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    check("done_start_busy", busy, 1'b0);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("extra_done_count", nd, 0);

    // Reset at cycle 8 of RUN aborts without a done pulse
    @(negedge clk);
    start = 1'b1; op = SEQ_OP_DIVU; opa = 16'hFFFF; opb = 16'h0003;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_res_hi", res_hi, 16'h0);
    check("abort_res_lo", res_lo, 16'h0);
    check("abort_dz", dz, 1'b0);
    nd = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);

    run_op("post_rst_mul", SEQ_OP_MUL, 16'h0003, 16'h0007, 16'h0000, 16'h0015, 1'b0, 17);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
